div_radix2: RTL and testbench

//  Sequential radix-2 restoring divider; responder side of the ALU's DIV/DIVU start/ready handshake.

---
 rtl/div_radix2_pkg.sv | 13 +
 rtl/div_step.sv | 28 ++
 rtl/div_radix2.sv | 134 +++++++++++++
 tb/tb_div_radix2.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state codes and iteration count.
package div_radix2_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   localparam int DIV_CYCLES = 32;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left, subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // The restored remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
   assign shifted = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};

   always_comb begin
      rem_nxt = shifted;
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
      if (shifted >= {1'b0, divisor}) begin
         rem_nxt    = diff;
         quo_nxt[0] = 1'b1;
      end
   end

endmodule

// File: rtl/div_radix2.sv
// Sequential radix-2 restoring divider (DIV/DIVU) with start/ready handshake and annul.
// Optional: define DIV_FAST_ZERO_EN to bypass the iterations when the divisor is zero.
module div_radix2
   import div_radix2_pkg::*;
#(
   parameter int WIDTH = DIV_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               start,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   dvs_q;
   logic               sgn_q;
   logic               a_neg_q;
   logic               b_neg_q;
   logic [2*WIDTH-1:0] result_q;
   logic [WIDTH:0]     rem_step;
   logic [WIDTH-1:0]   quo_step;
   logic               zero_div;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic is_signed);
      logic signed [WIDTH-1:0] xs;
      xs = x;
      return (is_signed && x[WIDTH-1]) ? $unsigned(-xs) : x;
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x,
                                                  input logic neg);
      logic signed [WIDTH-1:0] xs;
      xs = x;
      return neg ? $unsigned(-xs) : x;
   endfunction

`ifdef DIV_FAST_ZERO_EN
   assign zero_div = (opdata2 == '0);
`else
   assign zero_div = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem_step_src()),
      .quo     (quo_q),
      .divisor (dvs_q),
      .rem_nxt (rem_step),
      .quo_nxt (quo_step)
   );

   function automatic logic [WIDTH:0] rem_step_src();
      return rem_q;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= DIV_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (annul) begin
         state_d = DIV_IDLE;
      end else begin
         case (state_q)
            DIV_IDLE: if (start) state_d = zero_div ? DIV_FIX : DIV_BUSY;
            DIV_BUSY: if (cnt_q == LAST_CNT) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: if (!start) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
         endcase
      end
   end

   // Datapath: operands latched in IDLE, one step per BUSY cycle, sign fix-up in FIX.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         result_q <= '0;
      end else if (!annul) begin
         case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  dvs_q   <= magnitude(opdata2, signed_div);
                  sgn_q   <= signed_div;
                  a_neg_q <= opdata1[WIDTH-1];
                  b_neg_q <= opdata2[WIDTH-1];
                  cnt_q   <= '0;
                  if (zero_div) begin
                     // Same values the full iteration would produce for a zero divisor.
                     rem_q <= {1'b0, magnitude(opdata1, signed_div)};
                     quo_q <= '1;
                  end else begin
                     rem_q <= '0;
                     quo_q <= magnitude(opdata1, signed_div);
                  end
               end
            end
            DIV_BUSY: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            DIV_FIX: begin
               result_q <= {negate_if(rem_q[WIDTH-1:0], sgn_q && a_neg_q),
                            negate_if(quo_q, sgn_q && (a_neg_q ^ b_neg_q))};
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign ready  = (state_q == DIV_DONE);

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed cases plus randomized operands against an arithmetic model.
module tb_div_radix2;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic        start;
   logic        annul;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic [63:0] result;
   logic        ready;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_res = 64'd0;

`ifdef DIV_FAST_ZERO_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 34;
`endif
   localparam int LAT = 34;

   always #5 clk = ~clk;

   div_radix2 #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .start      (start),
      .annul      (annul),
      .result     (result),
      .ready      (ready)
   );

   // Reference: plain magnitude division, zero divisor gives all-ones quotient and |a| remainder.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ma, mb, mq, mr;
      logic [31:0] q, r;
      ma = (s && a[31]) ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
      mb = (s && b[31]) ? (64'd4294967296 - {32'd0, b}) : {32'd0, b};
      if (mb == 0) begin
         mq = 64'hFFFF_FFFF;
         mr = ma;
      end else begin
         mq = ma / mb;
         mr = ma % mb;
      end
      q = mq[31:0];
      r = mr[31:0];
      if (s && (a[31] ^ b[31])) q = -q;
      if (s && a[31]) r = -r;
      return {r, q};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
      signed_div = s;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
   endtask

   // Waits for ready from the next edge on, then checks latency, result, hold and release.
   task automatic finish(input string tag, input int exp_lat, input logic [63:0] exp,
                         input logic toggle);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (toggle && lat == 5) begin
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
         end
      end while (!ready && lat < 200);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, result, exp);
      @(negedge clk);
      chk({tag, "_hold"}, {63'd0, ready}, 64'd1);
      start = 1'b0;
      @(negedge clk);
      chk({tag, "_drop"}, {63'd0, ready}, 64'd0);
      chk({tag, "_keep"}, result, exp);
      last_res = exp;
   endtask

   initial begin
      logic        seen;
      logic        s;
      logic [31:0] a, b;

      rst   = 1'b1;
      annul = 1'b0;
      launch(1'b0, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'd0, ready}, 64'd0);
      chk("rst_result", result, 64'd0);
      rst = 1'b0;
      finish("divu_100_7", LAT, 64'h00000002_0000000E, 1'b0);

      launch(1'b1, -32'sd7, 32'd2);
      finish("div_m7_2", LAT, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
      launch(1'b1, 32'd7, -32'sd2);
      finish("div_7_m2", LAT, 64'h00000001_FFFFFFFD, 1'b0);
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      finish("div_ovf", LAT, 64'h00000000_80000000, 1'b0);
      launch(1'b0, 32'd7, 32'd0);
      finish("divu_7_0", ZLAT, 64'h00000007_FFFFFFFF, 1'b0);

      // Abort mid-iteration: no ready, previous result untouched.
      launch(1'b0, 32'd50, 32'd5);
      repeat (10) @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("annul_ready", {63'd0, ready}, 64'd0);
      annul = 1'b0;
      seen  = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      chk("annul_never_ready", {63'd0, seen}, 64'd0);
      chk("annul_keep", result, last_res);
      launch(1'b0, 32'd9, 32'd3);
      finish("divu_9_3", LAT, 64'h00000000_00000003, 1'b0);

      // annul outranks start while idle.
      launch(1'b1, -32'sd100, 32'd9);
      annul = 1'b1;
      repeat (3) @(negedge clk);
      chk("annul_idle_ready", {63'd0, ready}, 64'd0);
      annul = 1'b0;
      finish("div_m100_9", LAT, model(1'b1, -32'sd100, 32'd9), 1'b0);

      for (int i = 0; i < 10; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
         if (i == 7) b = 32'd0;
         if (i == 4) b = 32'hFFFF_FFFF;
         launch(s, a, b);
         finish($sformatf("rand%0d", i), (b == 32'd0) ? ZLAT : LAT, model(s, a, b), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
